cv_csbus_master: RTL
====================

Name: cv_csbus_master

Overview:
Initiator for the PS control-space bus (ps_c_*) that the csmem register blocks respond to. It accepts single read or write requests on a valid/ready request port and drives exactly one ps_c_en strobe per request. For reads, it waits for ps_c_dout_en with a bounded timeout, and it returns one response per request on a valid/ready response port. It is used by on-chip sequencers to program control registers without the PS.

Parameters:
TIMEOUT, 15, read-wait cycles before declaring no responder (1..255)
ERRCNT_W, 8, width of saturating error counter

Ports:
ps_c_clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_addr  in  19  byte address driven onto ps_c_addr
req_wdata  in  32  write data
req_we  in  4  byte write enables; 4'b0000 = read
resp_valid  out  1  response present
resp_ready  in  1  response consumed when valid&ready
resp_rdata  out  32  read data (0 for writes and timeouts)
resp_err  out  1  1 = read timed out
ps_c_addr  out  19  bus address
ps_c_din  out  32  bus write data
ps_c_we  out  4  bus byte enables
ps_c_en  out  1  bus strobe, one cycle per transaction
ps_c_dout  in  32  read data from responder(s)
ps_c_dout_en  in  1  read data valid, one cycle after the responder samples ps_c_en
busy  out  1  state != IDLE
err_count  out  ERRCNT_W  saturating count of timeouts

Behaviour:
- Single clock ps_c_clk. reset is synchronous and active-high; all state and outputs clear on the rising edge while reset=1.
- Reset values: state IDLE, req_ready=0 during reset and 1 in the first cycle after reset deasserts. resp_valid=0, resp_rdata=0, resp_err=0, ps_c_en=0, ps_c_addr=0, ps_c_din=0, ps_c_we=0, err_count=0, busy=0.
- All outputs are registered except req_ready and busy, which decode state.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1 the request is accepted. At that edge, register ps_c_addr=req_addr, ps_c_din=req_wdata, ps_c_we=req_we, ps_c_en=1. Next state is ISSUE.
- ISSUE (exactly 1 cycle): ps_c_en=1 is visible on the bus. At the exiting edge, ps_c_en and ps_c_we are cleared; ps_c_addr and ps_c_din hold their values.
  - Write (we!=0): load resp_rdata=0, resp_err=0, resp_valid=1; go to RESP.
  - Read: clear the wait counter to 0; go to WAIT.
- WAIT: ps_c_dout_en is sampled only in this state. Any dout_en seen in IDLE, ISSUE or RESP, or after a write, is ignored.
  - dout_en=1: resp_rdata=ps_c_dout, resp_err=0, resp_valid=1; go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without dout_en: resp_rdata=0, resp_err=1, resp_valid=1, err_count increments (saturating at all-ones); go to RESP.
  - If dout_en arrives on the same cycle the count reaches TIMEOUT-1, data wins and err=0.
- Nominal read latency: accept at edge N, ps_c_en high in cycle N+1, dout_en in cycle N+2, resp_valid from cycle N+3.
- Nominal write latency: resp_valid from cycle N+2.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready=1. On the handshake edge, resp_valid goes to 0 and the state returns to IDLE. A new request cannot be accepted on that same edge, so maximum throughput is one transaction per 3 cycles for writes and 4 for reads.
- One outstanding transaction at most. req_ready=0 in every state except IDLE.
- Reset mid-operation: the transaction is abandoned and no response is produced. ps_c_en is guaranteed low in the cycle after the reset edge.
- ps_c_en is never high for two consecutive cycles.

Test Plan:
- Write: req addr=0x7D020, wdata=0xA1B2C3D4, we=4'hF -> one-cycle ps_c_en with those values on the bus, then resp_valid with rdata=0, err=0; bus we=0 afterwards.
- Read hit: req addr=0x7D020, we=0; responder model returns dout=0x11223344 with dout_en one cycle after en -> resp_rdata=0x11223344, err=0, resp_valid 3 cycles after accept.
- Read timeout: no dout_en, TIMEOUT=15 -> resp_err=1, rdata=0, err_count 0->1. Repeat 300 times with ERRCNT_W=8 -> err_count saturates at 255.
- Backpressure: hold resp_ready=0 for 10 cycles -> resp fields stable, req_ready=0, and a new req_valid is not accepted. When resp_ready rises, the handshake completes and req_ready=1 on the next cycle.
- Stray dout_en: assert dout_en during ISSUE of a write and in IDLE -> no extra response and no data capture. Assert dout_en in the last timeout cycle -> data captured with err=0.
- Reset during WAIT: pulse reset while waiting for a read -> no resp_valid, all outputs at reset values, and the next request completes normally.

Source files
------------

// File: rtl/cv_csbus_master.sv
// Initiator for the PS control-space bus: one ps_c_en strobe per request.
// Reads wait for ps_c_dout_en or time out. Each request gets exactly one response.
module cv_csbus_master #(
  parameter int TIMEOUT  = 15,
  parameter int ERRCNT_W = 8
) (
  input  logic                ps_c_clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [18:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_we,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [18:0]         ps_c_addr,
  output logic [31:0]         ps_c_din,
  output logic [3:0]          ps_c_we,
  output logic                ps_c_en,
  input  logic [31:0]         ps_c_dout,
  input  logic                ps_c_dout_en,
  output logic                busy,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       is_write;
  logic       wait_last;

  assign is_write  = (ps_c_we != 4'b0000);
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge ps_c_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid)                  state_nxt = ISSUE;
      ISSUE: state_nxt = is_write ? RESP : WAIT;
      WAIT:  if (ps_c_dout_en || wait_last)  state_nxt = RESP;
      RESP:  if (resp_ready)                 state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // The strobe defaults low every cycle, so it can only ever be a single-cycle pulse.
  always_ff @(posedge ps_c_clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      ps_c_addr  <= '0;
      ps_c_din   <= '0;
      ps_c_we    <= '0;
      ps_c_en    <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      ps_c_en <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          ps_c_addr <= req_addr;
          ps_c_din  <= req_wdata;
          ps_c_we   <= req_we;
          ps_c_en   <= 1'b1;
        end
        ISSUE: begin
          ps_c_we  <= '0;
          wait_cnt <= '0;
          if (is_write) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end
        end
        WAIT: begin
          // Data arriving in the final wait cycle still beats the timeout.
          if (ps_c_dout_en) begin
            resp_rdata <= ps_c_dout;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end else if (wait_last) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
